// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control plane for a 5-stage (IF, ID, EX, MEM, WB) datapath.
// It owns the fetch PC and the per-stage valid bits, and it tracks destination registers
// through EX, MEM and WB. From these records it derives the operand-forwarding selects,
// load-use stalls and branch flushes. Saturating stall and flush counters aid performance debug.
module pipe_hazard_ctrl #(
    parameter int unsigned      ISIZE    = 16,
    parameter int unsigned      RSIZE    = 4,
    parameter logic [ISIZE-1:0] RESET_PC = '0,
    parameter bit               ZERO_REG = 1'b1,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // Instruction currently in ID
    input  logic [RSIZE-1:0] id_rs1_i,
    input  logic [RSIZE-1:0] id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [RSIZE-1:0] id_rd_i,
    input  logic             id_wen_i,
    input  logic             id_load_i,
    input  logic             id_mem_wen_i,
    // Branch resolution from EX
    input  logic             ex_br_taken_i,
    input  logic [ISIZE-1:0] ex_target_i,
    // Fetch and stage status
    output logic [ISIZE-1:0] pc_o,
    output logic             id_valid_o,
    output logic             ex_valid_o,
    output logic             mem_valid_o,
    output logic             wb_valid_o,
    output logic             id_hold_o,
    // Datapath controls
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             dmem_wen_o,
    output logic             rf_wen_o,
    output logic [RSIZE-1:0] rf_waddr_o,
    // Performance counters
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [1:0] FwdRf  = 2'd0;
    localparam logic [1:0] FwdMem = 2'd1;
    localparam logic [1:0] FwdWb  = 2'd2;

    // EX keeps the source fields so that forwarding can be resolved one stage later
    typedef struct packed {
        logic             valid;
        logic [RSIZE-1:0] rd;
        logic             wen;
        logic             load;
        logic             mem_wen;
        logic [RSIZE-1:0] rs1;
        logic [RSIZE-1:0] rs2;
        logic             rs1_used;
        logic             rs2_used;
    } ex_rec_t;

    typedef struct packed {
        logic             valid;
        logic [RSIZE-1:0] rd;
        logic             wen;
        logic             load;
        logic             mem_wen;
    } res_rec_t;

    logic [ISIZE-1:0] pc_q, pc_d;
    logic             id_valid_q, id_valid_d;
    ex_rec_t          ex_q, ex_d;
    res_rec_t         mem_q, mem_d;
    res_rec_t         wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic flush;
    logic luh;
    logic stall;

    // A destination participates in hazards only if it is not the hardwired zero register
    function automatic logic rd_live(input logic [RSIZE-1:0] r);
        return !(ZERO_REG && (r == '0));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Hazard detection: a load in EX whose result the instruction in ID needs
    always_comb begin
        luh = 1'b0;
        if (ex_q.valid && ex_q.load && ex_q.wen && id_valid_q && rd_live(ex_q.rd)) begin
            luh = (id_rs1_used_i && (id_rs1_i == ex_q.rd)) ||
                  (id_rs2_used_i && (id_rs2_i == ex_q.rd));
        end
        flush = ex_q.valid && ex_br_taken_i;
        // A stall request in a flush cycle is dropped: the instruction in ID is squashed anyway
        stall = luh && !flush;
    end

    // Next-state for PC, ID valid, stage records and counters
    always_comb begin
        pc_d        = pc_q;
        id_valid_d  = id_valid_q;
        ex_d        = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            pc_d        = ex_target_i;
            id_valid_d  = 1'b0;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (stall) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            pc_d        = pc_q + ISIZE'(1);
            id_valid_d  = 1'b1;
            ex_d.valid    = id_valid_q;
            ex_d.rd       = id_rd_i;
            ex_d.wen      = id_wen_i;
            ex_d.load     = id_load_i;
            ex_d.mem_wen  = id_mem_wen_i;
            ex_d.rs1      = id_rs1_i;
            ex_d.rs2      = id_rs2_i;
            ex_d.rs1_used = id_rs1_used_i;
            ex_d.rs2_used = id_rs2_used_i;
        end

        // MEM and WB advance unconditionally
        mem_d.valid   = ex_q.valid;
        mem_d.rd      = ex_q.rd;
        mem_d.wen     = ex_q.wen;
        mem_d.load    = ex_q.load;
        mem_d.mem_wen = ex_q.mem_wen;
        wb_d          = mem_q;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            id_valid_q  <= 1'b0;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            id_valid_q  <= id_valid_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

    // Producer matches; a load in MEM has no result yet and is never a forwarding source
    always_comb begin
        mem_hit_a = mem_q.valid && mem_q.wen && !mem_q.load && rd_live(mem_q.rd) &&
                    ex_q.rs1_used && (mem_q.rd == ex_q.rs1);
        mem_hit_b = mem_q.valid && mem_q.wen && !mem_q.load && rd_live(mem_q.rd) &&
                    ex_q.rs2_used && (mem_q.rd == ex_q.rs2);
        wb_hit_a  = wb_q.valid && wb_q.wen && rd_live(wb_q.rd) &&
                    ex_q.rs1_used && (wb_q.rd == ex_q.rs1);
        wb_hit_b  = wb_q.valid && wb_q.wen && rd_live(wb_q.rd) &&
                    ex_q.rs2_used && (wb_q.rd == ex_q.rs2);
    end

    // Operand selects: the younger result (MEM) wins over WB
    always_comb begin
        fwd_a_o = FwdRf;
        fwd_b_o = FwdRf;
        if (ex_q.valid) begin
            if (mem_hit_a) begin
                fwd_a_o = FwdMem;
            end else if (wb_hit_a) begin
                fwd_a_o = FwdWb;
            end
            if (mem_hit_b) begin
                fwd_b_o = FwdMem;
            end else if (wb_hit_b) begin
                fwd_b_o = FwdWb;
            end
        end
    end

    // WB's load and store flags are carried for record symmetry and debug visibility only
    logic unused_wb_flags;
    assign unused_wb_flags = wb_q.load ^ wb_q.mem_wen;

    assign pc_o        = pc_q;
    assign id_valid_o  = id_valid_q;
    assign ex_valid_o  = ex_q.valid;
    assign mem_valid_o = mem_q.valid;
    assign wb_valid_o  = wb_q.valid;
    assign id_hold_o   = stall;
    assign dmem_wen_o  = mem_q.valid && mem_q.mem_wen;
    assign rf_wen_o    = wb_q.valid && wb_q.wen;
    assign rf_waddr_o  = wb_q.rd;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

`ifndef SYNTHESIS
    a_fwd_a_legal: assert property (@(posedge clk_i) disable iff (rst_i) fwd_a_o != 2'd3);
    a_fwd_b_legal: assert property (@(posedge clk_i) disable iff (rst_i) fwd_b_o != 2'd3);
    a_hold_not_flush: assert property (@(posedge clk_i) disable iff (rst_i)
                                       !(id_hold_o && flush));
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic, all checked each cycle
// against an in-bench model that tracks in-flight instructions by stage distance.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rs1, rs2, rd;
    logic        u1, u2, wen, ld, st, br;
    logic [15:0] tgt;

    logic [15:0] pc_a, pc_b;
    logic        idv_a, exv_a, memv_a, wbv_a, hold_a, dmem_a, rfw_a;
    logic        idv_b, exv_b, memv_b, wbv_b, hold_b, dmem_b, rfw_b;
    logic [1:0]  fwa_a, fwb_a, fwa_b, fwb_b;
    logic [3:0]  waddr_a, waddr_b;
    logic [15:0] stall_a, flush_a;
    logic [1:0]  stall_b, flush_b;

    pipe_hazard_ctrl u_dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
        .id_rd_i(rd), .id_wen_i(wen), .id_load_i(ld), .id_mem_wen_i(st),
        .ex_br_taken_i(br), .ex_target_i(tgt),
        .pc_o(pc_a), .id_valid_o(idv_a), .ex_valid_o(exv_a), .mem_valid_o(memv_a),
        .wb_valid_o(wbv_a), .id_hold_o(hold_a), .fwd_a_o(fwa_a), .fwd_b_o(fwb_a),
        .dmem_wen_o(dmem_a), .rf_wen_o(rfw_a), .rf_waddr_o(waddr_a),
        .stall_cnt_o(stall_a), .flush_cnt_o(flush_a)
    );

    // Second instance: PC wrap from all-ones and narrow saturating counters
    pipe_hazard_ctrl #(.RESET_PC(16'hFFFF), .CNT_W(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
        .id_rd_i(rd), .id_wen_i(wen), .id_load_i(ld), .id_mem_wen_i(st),
        .ex_br_taken_i(br), .ex_target_i(tgt),
        .pc_o(pc_b), .id_valid_o(idv_b), .ex_valid_o(exv_b), .mem_valid_o(memv_b),
        .wb_valid_o(wbv_b), .id_hold_o(hold_b), .fwd_a_o(fwa_b), .fwd_b_o(fwb_b),
        .dmem_wen_o(dmem_b), .rf_wen_o(rfw_b), .rf_waddr_o(waddr_b),
        .stall_cnt_o(stall_b), .flush_cnt_o(flush_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        bit       v;
        bit [3:0] rd;
        bit       w;
        bit       ld;
        bit       st;
        bit [3:0] rs1;
        bit [3:0] rs2;
        bit       u1;
        bit       u2;
    } rec_t;

    rec_t        pipe [3];   // index = distance past ID: 0 EX, 1 MEM, 2 WB
    bit   [15:0] m_pc, m_pcb;
    bit          m_idv;
    int          m_stall, m_flush;
    bit          m_last_hold;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit m_luh();
        if (!(pipe[0].v && pipe[0].ld && pipe[0].w && m_idv) || pipe[0].rd == 4'd0) return 1'b0;
        return (u1 && rs1 == pipe[0].rd) || (u2 && rs2 == pipe[0].rd);
    endfunction

    // Youngest older instruction that has produced the register; a load one stage ahead
    // has not produced it yet
    function automatic bit [1:0] m_fwd(input bit [3:0] r, input bit used);
        if (!pipe[0].v || !used) return 2'd0;
        for (int d = 1; d <= 2; d++) begin
            if (pipe[d].v && pipe[d].w && pipe[d].rd == r && r != 4'd0 &&
                !(d == 1 && pipe[d].ld)) return 2'(d);
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_pc = 16'h0000; m_pcb = 16'hFFFF; m_idv = 1'b0;
        m_stall = 0; m_flush = 0; m_last_hold = 1'b0;
    endtask

    task automatic model_step();
        bit   fl, hd;
        rec_t nx;
        fl = pipe[0].v && br;
        hd = m_luh() && !fl;
        m_last_hold = hd;
        nx = '0;
        if (!fl && !hd) begin
            nx.v = m_idv; nx.rd = rd; nx.w = wen; nx.ld = ld; nx.st = st;
            nx.rs1 = rs1; nx.rs2 = rs2; nx.u1 = u1; nx.u2 = u2;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nx;
        if (fl) begin
            m_pc = tgt; m_pcb = tgt; m_idv = 1'b0; m_flush++;
        end else if (hd) begin
            m_stall++;
        end else begin
            m_pc++; m_pcb++; m_idv = 1'b1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        bit fl, hd;
        fl = pipe[0].v && br;
        hd = m_luh() && !fl;
        chk("pc",        32'(pc_a),    32'(m_pc));
        chk("id_valid",  32'(idv_a),   32'(m_idv));
        chk("ex_valid",  32'(exv_a),   32'(pipe[0].v));
        chk("mem_valid", 32'(memv_a),  32'(pipe[1].v));
        chk("wb_valid",  32'(wbv_a),   32'(pipe[2].v));
        chk("id_hold",   32'(hold_a),  32'(hd));
        chk("fwd_a",     32'(fwa_a),   32'(m_fwd(pipe[0].rs1, pipe[0].u1)));
        chk("fwd_b",     32'(fwb_a),   32'(m_fwd(pipe[0].rs2, pipe[0].u2)));
        chk("dmem_wen",  32'(dmem_a),  32'(pipe[1].v && pipe[1].st));
        chk("rf_wen",    32'(rfw_a),   32'(pipe[2].v && pipe[2].w));
        chk("rf_waddr",  32'(waddr_a), 32'(pipe[2].rd));
        chk("stall_cnt", 32'(stall_a), 32'(sat(m_stall, 65535)));
        chk("flush_cnt", 32'(flush_a), 32'(sat(m_flush, 65535)));
        chk("b_pc",        32'(pc_b),    32'(m_pcb));
        chk("b_id_hold",   32'(hold_b),  32'(hd));
        chk("b_stall_cnt", 32'(stall_b), 32'(sat(m_stall, 3)));
        chk("b_flush_cnt", 32'(flush_b), 32'(sat(m_flush, 3)));
    endtask

    // Observations of the most recent cycle, for literal expectations
    logic [15:0] o_pc, o_pcb;
    logic        o_idv, o_exv, o_hold, o_rfw;
    logic [1:0]  o_fwa, o_fwb;

    // Called at a falling edge; drives ID/EX inputs, checks, steps the model, returns at the
    // next falling edge
    task automatic do_cycle(input logic [3:0] a1, input logic [3:0] a2, input logic b1,
                            input logic b2, input logic [3:0] d, input logic w, input logic l,
                            input logic s, input logic b, input logic [15:0] t);
        rs1 = a1; rs2 = a2; u1 = b1; u2 = b2; rd = d; wen = w; ld = l; st = s;
        br = b; tgt = t;
        #1;
        compare_all();
        o_pc = pc_a; o_pcb = pc_b; o_idv = idv_a; o_exv = exv_a; o_hold = hold_a;
        o_rfw = rfw_a; o_fwa = fwa_a; o_fwb = fwb_a;
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic nop();
        do_cycle(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic reset_dut();
        rst = 1'b1;
        #1;
        chk("rst_pc",        32'(pc_a),   32'h0000);
        chk("rst_b_pc",      32'(pc_b),   32'hFFFF);
        chk("rst_valids",    32'({idv_a, exv_a, memv_a, wbv_a}), 32'h0);
        chk("rst_dmem_wen",  32'(dmem_a), 32'h0);
        chk("rst_rf_wen",    32'(rfw_a),  32'h0);
        chk("rst_id_hold",   32'(hold_a), 32'h0);
        chk("rst_fwd",       32'({fwa_a, fwb_a}), 32'h0);
        chk("rst_counters",  32'({stall_a, flush_a}), 32'h0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic pc_sequence_check(input string tag);
        nop(); chk({tag, "_pc0"}, 32'(o_pc), 32'h0000); chk({tag, "_b_pc0"}, 32'(o_pcb), 32'hFFFF);
        nop(); chk({tag, "_pc1"}, 32'(o_pc), 32'h0001); chk({tag, "_b_pc1"}, 32'(o_pcb), 32'h0000);
        nop(); chk({tag, "_pc2"}, 32'(o_pc), 32'h0002); chk({tag, "_b_pc2"}, 32'(o_pcb), 32'h0001);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0]  r_rs1, r_rs2, r_rd;
        logic        r_u1, r_u2, r_wen, r_ld, r_st;
        bit          keep;

        rs1 = '0; rs2 = '0; rd = '0; u1 = 0; u2 = 0; wen = 0; ld = 0; st = 0; br = 0; tgt = '0;
        #2;
        reset_dut();
        pc_sequence_check("start");

        // ALU chain: R1 = op; R2 = R1 op R3; R4 = R1 op R2
        do_cycle(4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        do_cycle(4'd1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        do_cycle(4'd1, 4'd2, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("alu2_fwd_a", 32'(o_fwa), 32'd1);
        chk("alu2_fwd_b", 32'(o_fwb), 32'd0);
        nop();
        chk("alu3_fwd_a", 32'(o_fwa), 32'd2);
        chk("alu3_fwd_b", 32'(o_fwb), 32'd1);
        chk("alu_stall_cnt", 32'(stall_a), 32'd0);

        // Load-use: load R5, consumer reads R5 as rs2
        do_cycle(4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        do_cycle(4'd0, 4'd5, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("lu_hold", 32'(o_hold), 32'd1);
        do_cycle(4'd0, 4'd5, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("lu_bubble_ex_valid", 32'(o_exv), 32'd0);
        chk("lu_hold_released", 32'(o_hold), 32'd0);
        nop();
        chk("lu_fwd_b", 32'(o_fwb), 32'd2);
        chk("lu_stall_cnt", 32'(stall_a), 32'd1);

        // Taken branch resolved in EX; the two younger instructions write R7 if they survive
        nop();
        do_cycle(4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0040);
        do_cycle(4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("br_pc", 32'(o_pc), 32'h0040);
        chk("br_id_valid", 32'(o_idv), 32'd0);
        chk("br_ex_valid1", 32'(o_exv), 32'd0);
        chk("br_rf_wen1", 32'(o_rfw), 32'd0);
        nop();
        chk("br_ex_valid2", 32'(o_exv), 32'd0);
        chk("br_target_in_id", 32'(o_idv), 32'd1);
        chk("br_rf_wen2", 32'(o_rfw), 32'd0);
        nop(); chk("br_rf_wen3", 32'(o_rfw), 32'd0);
        nop(); chk("br_rf_wen4", 32'(o_rfw), 32'd0);
        chk("br_flush_cnt", 32'(flush_a), 32'd1);

        // Branch and load-use in the same cycle: flush wins, stall not counted
        do_cycle(4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        do_cycle(4'd5, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0080);
        chk("brst_hold", 32'(o_hold), 32'd0);
        nop();
        chk("brst_pc", 32'(o_pc), 32'h0080);
        chk("brst_stall_cnt", 32'(stall_a), 32'd1);
        chk("brst_flush_cnt", 32'(flush_a), 32'd2);
        nop();

        // Register 0: load to R0 then use R0 (no stall); ALU to R0 then use R0 (no forward)
        do_cycle(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        do_cycle(4'd0, 4'd0, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("r0_no_hold", 32'(o_hold), 32'd0);
        do_cycle(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("r0_load_fwd", 32'({o_fwa, o_fwb}), 32'd0);
        do_cycle(4'd0, 4'd0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        nop();
        chk("r0_alu_fwd_a", 32'(o_fwa), 32'd0);
        chk("r0_stall_cnt", 32'(stall_a), 32'd1);

        // Four more load-use stalls: the 2-bit counter sticks at 3
        repeat (4) begin
            do_cycle(4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
            do_cycle(4'd0, 4'd5, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
            do_cycle(4'd0, 4'd5, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        end
        nop();
        chk("sat_stall_cnt", 32'(stall_a), 32'd5);
        chk("sat_b_stall_cnt", 32'(stall_b), 32'd3);

        // Store reaches MEM, then reset mid-cycle
        do_cycle(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        nop();
        #1;
        chk("store_in_mem", 32'(dmem_a), 32'd1);
        reset_dut();
        pc_sequence_check("rerst");

        // Randomized traffic on a small register set so that hazards are frequent
        keep = 1'b0;
        r_rs1 = '0; r_rs2 = '0; r_rd = '0; r_u1 = 0; r_u2 = 0; r_wen = 0; r_ld = 0; r_st = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_dut();
                keep = 1'b0;
            end else begin
                // A held instruction must be presented unchanged
                if (!keep) begin
                    r_rs1 = 4'($urandom_range(0, 3));
                    r_rs2 = 4'($urandom_range(0, 3));
                    r_rd  = 4'($urandom_range(0, 3));
                    r_u1  = 1'($urandom_range(0, 1));
                    r_u2  = 1'($urandom_range(0, 1));
                    r_ld  = ($urandom_range(0, 2) == 0);
                    r_wen = ($urandom_range(0, 3) != 0);
                    r_st  = !r_ld && ($urandom_range(0, 4) == 0);
                end
                do_cycle(r_rs1, r_rs2, r_u1, r_u2, r_rd, r_wen, r_ld, r_st,
                         1'($urandom_range(0, 5) == 0), 16'($urandom));
                keep = m_last_hold;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline control plane for the 5-stage (IF, ID, EX, MEM, WB) 16-bit datapath.

- Owns the fetch PC and the per-stage valid bits.
- Tracks destination registers through EX, MEM and WB.
- Generates operand-forwarding selects, load-use stalls and branch flushes, so the datapath executes back-to-back dependent instructions correctly.
- Keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- ISIZE, 16, PC and branch-target width
- RSIZE, 4, register address width
- RESET_PC, 0, PC value loaded on reset
- ZERO_REG, 1, if 1 register 0 is hardwired: it never creates a hazard and is never forwarded
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset; asynchronous, active-high
- id_rs1, id_rs2  in  RSIZE  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  RSIZE  destination of the instruction in ID
- id_wen  in  1  instruction in ID writes the register file
- id_load  in  1  instruction in ID is a load
- id_mem_wen  in  1  instruction in ID is a store
- ex_br_taken  in  1  branch resolved taken in EX
- ex_target  in  ISIZE  branch target from EX
- pc  out  ISIZE  fetch address
- id_valid, ex_valid, mem_valid, wb_valid  out  1  stage holds a real instruction
- id_hold  out  1  ID/IF registers must hold this cycle
- fwd_a, fwd_b  out  2  EX operand select: 0 = regfile, 1 = EX/MEM result, 2 = MEM/WB result
- dmem_wen  out  1  store enable, gated by mem_valid
- rf_wen  out  1  register write enable, gated by wb_valid
- rf_waddr  out  RSIZE  writeback address
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
Stage records:
- Each of EX, MEM and WB registers {valid, rd, wen, load, mem_wen, rs1, rs2, rs1_used, rs2_used}. Source fields are kept only in EX.
- Records advance every cycle.

Load-use hazard (`luh`), combinational:
- Condition: ex_valid & ex.load & ex.wen & id_valid, and ex.rd equals (id_rs1 & id_rs1_used) or (id_rs2 & id_rs2_used).
- When ZERO_REG=1 and rd = 0, `luh` is forced to 0.

Flush:
- Condition: `flush` = ex_valid & ex_br_taken.

Per-edge update, in priority order:
- **flush:**
  - pc <= ex_target.
  - id_valid <= 0.
  - EX record <= bubble (valid 0).
  - flush_cnt += 1.
- **else luh:**
  - pc holds; id_valid holds.
  - EX record <= bubble.
  - id_hold = 1.
  - stall_cnt += 1.
- **else:**
  - pc <= pc + 1, modulo 2^ISIZE; all-ones wraps to 0.
  - id_valid <= 1.
  - EX record <= ID fields with valid = id_valid.
- In every case MEM <= EX and WB <= MEM.
- Flush outranks stall: a stall request in the flush cycle is dropped and is not counted.

Forwarding, combinational from the registered records, per operand X in {a, b}:
- fwd_X = 1 if mem_valid & mem.wen & !mem.load & mem.rd == ex.rsX & ex.rsX_used.
- else fwd_X = 2 if wb_valid & wb.wen & wb.rd == ex.rsX & ex.rsX_used.
- else fwd_X = 0.
- MEM outranks WB (younger result wins).
- Loads in MEM are never forwarded; `luh` guarantees this case never needs to be.
- ZERO_REG=1: rd = 0 never matches.
- fwd_X = 0 when ex_valid = 0.

Outputs:
- dmem_wen = mem_valid & mem.mem_wen.
- rf_wen = wb_valid & wb.wen.
- rf_waddr = wb.rd.

Counters:
- Saturate at all-ones; no wrap.

## Timing
- Reset (async) drives: pc = RESET_PC; id/ex/mem/wb_valid = 0; all stage records 0; counters 0. Consequently fwd_a = fwd_b = 0, dmem_wen = rf_wen = 0, id_hold = 0.
- First edge after rst deasserts: pc = RESET_PC+1 and id_valid = 1.
- Branch penalty is 2 bubbles.
  - Edge ending cycle N (flush): pc = target, id_valid = 0, ex_valid = 0.
  - At N+2, the target instruction is valid in ID.
- Load-use penalty is 1 bubble.
  - The consumer stays in ID for one extra cycle.
  - It then enters EX while the load is in WB, so fwd = 2.
- Reset asserted mid-operation clears everything within the same cycle, with no clock needed; no pending write survives.
- The ID inputs are sampled only on non-flush edges and must be stable while id_hold = 1.

## Test plan
- **Reset:** assert rst mid-run with a store in MEM → dmem_wen drops immediately, pc = RESET_PC; after release the pc sequence is 0, 1, 2, ….
- **ALU chain:** R1 = op, R2 = R1 op R3, R4 = R1 op R2 → second instruction fwd_a = 1; third fwd_a = 2, fwd_b = 1; no stall_cnt change.
- **Load-use:** load R5, then use R5 as rs2 → one cycle id_hold = 1 with ex_valid = 0 next; consumer then sees fwd_b = 2; stall_cnt = 1.
- **Branch:** ex_br_taken with ex_target = 0x0040 at cycle N → pc = 0x0040 at N+1; the two younger instructions never assert ex_valid or rf_wen; flush_cnt = 1.
- **Branch + stall together:** same cycle → flush wins, stall_cnt unchanged. ZERO_REG: load to R0, then use R0 → no stall, fwd = 0.
- **Wrap and saturate:** RESET_PC = 0xFFFF → next pc = 0x0000. With CNT_W = 2, four load-use stalls → stall_cnt = 3.
